// File: rtl/jts16_fd1094_pkg.sv
// Shared FD1094 definitions: channel FSM states, bit-swap tables and key-field positions.
package jts16_fd1094_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_FETCH,
        ST_LATCH,
        ST_DONE
    } ch_state_t;

    // Nibble i holds the source bit for result bit i (opcode: 5i+3 mod 16, data: 3i+7 mod 16).
    localparam logic [63:0] SWAP_OP   = 64'he94f_a50b_61c7_2d83;
    localparam logic [63:0] SWAP_DATA = 64'h41eb_852f_c963_0da7;

    localparam int KEY_SWAP_BIT = 7;
    localparam int KEY_HI_BIT   = 6;

    function automatic logic [15:0] bit_swap(input logic [15:0] w, input logic [63:0] tbl);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) r[i] = w[tbl[i*4 +: 4]];
        return r;
    endfunction

endpackage

// File: rtl/jts16_fd1094_if.sv
// Bus bundle between the CPU channels / key RAM and the shared FD1094 decryption front-end.
interface jts16_fd1094_if #(
    parameter int NCH = 2,
    parameter int AW  = 23,
    parameter int KAW = 13
);
    logic [KAW-1:0]    key_addr;
    logic              key_cs;
    logic [7:0]        key_data;
    logic [NCH-1:0]    dec_en;
    logic [NCH-1:0]    req;
    logic [NCH-1:0]    op_n;
    logic [NCH-1:0]    vrq;
    logic [8*NCH-1:0]  st;
    logic [8*NCH-1:0]  gkey0;
    logic [AW*NCH-1:0] addr;
    logic [16*NCH-1:0] enc;
    logic [16*NCH-1:0] dec;
    logic [NCH-1:0]    ok;

    modport slave (
        output key_addr, key_cs, dec, ok,
        input  key_data, dec_en, req, op_n, vrq, st, gkey0, addr, enc
    );

    modport master (
        input  key_addr, key_cs, dec, ok,
        output key_data, dec_en, req, op_n, vrq, st, gkey0, addr, enc
    );
endinterface

// File: rtl/jts16_fd1094_xlat.sv
// Combinational FD1094 word translation for one channel: key/state mask, then table bit-swap.
module jts16_fd1094_xlat
    import jts16_fd1094_pkg::*;
(
    input  logic [15:0] enc,
    input  logic [7:0]  key,
    input  logic [7:0]  st,
    input  logic [7:0]  gkey0,
    input  logic        op_n,
    input  logic        vrq,
    output logic [15:0] dec
);
    logic [7:0]  mask;
    logic [15:0] mixed;
    logic        data_path;

    always_comb begin
        mask      = key ^ gkey0 ^ st;
        // vector fetches always use the data-path table
        data_path = op_n | ~vrq;
        mixed     = enc ^ {(key[KEY_HI_BIT] ? mask : 8'h00), mask};
        if (key[KEY_SWAP_BIT])
            dec = bit_swap(mixed, data_path ? SWAP_DATA : SWAP_OP);
        else
            dec = mixed;
    end

endmodule

// File: rtl/jts16_fd1094_mux.sv
// Multi-channel FD1094 front-end: round-robin key RAM sharing and per-channel decrypt FSMs.
// Optional JTS16_FD1094_CACHE_EN adds a one-entry per-channel result cache.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | no request; waits for req (bypass/cache hit jumps to DONE)
// ST_WAIT  | decrypt requested, waiting for key port grant
// ST_FETCH | granted; key_cs/key_addr on the port this cycle
// ST_LATCH | key_data valid; dec registered on the next edge
// ST_DONE  | ok=1 until req drops
module jts16_fd1094_mux
    import jts16_fd1094_pkg::*;
#(
    parameter int NCH = 2,
    parameter int AW  = 23,
    parameter int KAW = 13
) (
    input  logic          clk,
    input  logic          rst_n,
    jts16_fd1094_if.slave bus
);
    localparam int PW = (NCH > 1) ? $clog2(NCH) : 1;

    logic [NCH-1:0] waiting;
    logic [NCH-1:0] grant;
    logic [PW-1:0]  ptr;
    logic [PW-1:0]  grant_idx;
    logic [PW:0]    arb_sum;
    logic [PW-1:0]  arb_idx;
    logic [KAW-1:0] ch_kaddr [NCH];

    // Search starts at ptr, which points one past the last granted channel.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        arb_sum   = '0;
        arb_idx   = '0;
        for (int k = 0; k < NCH; k++) begin
            arb_sum = {1'b0, ptr} + (PW+1)'(k);
            if (arb_sum >= (PW+1)'(NCH)) arb_sum = arb_sum - (PW+1)'(NCH);
            arb_idx = arb_sum[PW-1:0];
            if (grant == '0 && waiting[arb_idx]) begin
                grant[arb_idx] = 1'b1;
                grant_idx      = arb_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.key_cs   <= 1'b0;
            bus.key_addr <= '0;
            ptr          <= '0;
        end else begin
            bus.key_cs <= |grant;
            if (|grant) begin
                bus.key_addr <= ch_kaddr[grant_idx];
                ptr          <= (grant_idx == PW'(NCH-1)) ? '0 : grant_idx + 1'b1;
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        ch_state_t   state, state_nx;
        logic [15:0] dec_q;
        logic [15:0] xlat_dec;
        logic        req_i, en_i, hit;

        assign req_i       = bus.req[i];
        assign en_i        = bus.dec_en[i];
        assign ch_kaddr[i] = bus.addr[i*AW +: KAW];

        jts16_fd1094_xlat u_xlat (
            .enc   (bus.enc[i*16 +: 16]),
            .key   (bus.key_data),
            .st    (bus.st[i*8 +: 8]),
            .gkey0 (bus.gkey0[i*8 +: 8]),
            .op_n  (bus.op_n[i]),
            .vrq   (bus.vrq[i]),
            .dec   (xlat_dec)
        );

`ifdef JTS16_FD1094_CACHE_EN
        logic [AW-1:0] tag_addr;
        logic [7:0]    tag_st;
        logic          tag_op, tag_vrq, tag_valid;

        assign hit = tag_valid && (tag_addr == bus.addr[i*AW +: AW]) &&
                     (tag_st == bus.st[i*8 +: 8]) && (tag_op == bus.op_n[i]) &&
                     (tag_vrq == bus.vrq[i]);

        // dec_q itself is the cached word, so only the tag is stored here
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                tag_valid <= 1'b0;
                tag_addr  <= '0;
                tag_st    <= '0;
                tag_op    <= 1'b0;
                tag_vrq   <= 1'b0;
            end else if (state == ST_IDLE && req_i && !en_i) begin
                tag_valid <= 1'b0;
            end else if (state == ST_LATCH && req_i) begin
                tag_valid <= 1'b1;
                tag_addr  <= bus.addr[i*AW +: AW];
                tag_st    <= bus.st[i*8 +: 8];
                tag_op    <= bus.op_n[i];
                tag_vrq   <= bus.vrq[i];
            end
        end
`else
        assign hit = 1'b0;
`endif

        always_comb begin
            state_nx = state;
            case (state)
                ST_IDLE:  if (req_i) state_nx = (!en_i || hit) ? ST_DONE : ST_WAIT;
                ST_WAIT:  begin
                    if (!req_i)        state_nx = ST_IDLE;
                    else if (grant[i]) state_nx = ST_FETCH;
                end
                ST_FETCH: state_nx = req_i ? ST_LATCH : ST_IDLE;
                ST_LATCH: state_nx = req_i ? ST_DONE : ST_IDLE;
                ST_DONE:  if (!req_i) state_nx = ST_IDLE;
                default:  state_nx = ST_IDLE;
            endcase
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state <= ST_IDLE;
                dec_q <= '0;
            end else begin
                state <= state_nx;
                if (state == ST_IDLE && req_i && !en_i)
                    dec_q <= bus.enc[i*16 +: 16];
                else if (state == ST_LATCH && req_i)
                    dec_q <= xlat_dec;
            end
        end

        assign waiting[i]          = (state == ST_WAIT) && req_i;
        assign bus.ok[i]           = (state == ST_DONE);
        assign bus.dec[i*16 +: 16] = dec_q;
    end

endmodule

// File: tb/tb_jts16_fd1094_mux.sv
// Self-checking bench for jts16_fd1094_mux: directed cases plus randomized multi-channel requests.
module tb_jts16_fd1094_mux;
    localparam int NCH = 2;
    localparam int AW  = 23;
    localparam int KAW = 13;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    jts16_fd1094_if #(.NCH(NCH), .AW(AW), .KAW(KAW)) bus ();

    jts16_fd1094_mux #(.NCH(NCH), .AW(AW), .KAW(KAW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [7:0] kram [1<<KAW];
    always @(posedge clk) if (bus.key_cs) bus.key_data <= kram[bus.key_addr];

    int n_tests = 0;
    int n_fail  = 0;

    logic          c_en  [NCH];
    logic          c_op  [NCH];
    logic          c_vrq [NCH];
    logic [7:0]    c_st  [NCH];
    logic [7:0]    c_gk  [NCH];
    logic [AW-1:0] c_addr[NCH];
    logic [15:0]   c_enc [NCH];
    logic [15:0]   last_dec [NCH];
    int            ptr_m;

    logic          m_valid [NCH];
    logic [AW-1:0] m_addr  [NCH];
    logic [7:0]    m_st    [NCH];
    logic          m_op    [NCH];
    logic          m_vrq   [NCH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference decrypt: key/state mask, then affine bit permutation selected by fetch type.
    function automatic logic [15:0] ref_dec(input logic [15:0] e, input logic [7:0] k,
                                            input logic [7:0] s, input logic [7:0] g,
                                            input logic opn, input logic v);
        logic [7:0]  m;
        logic [15:0] x, y;
        int          src;
        m = k ^ g ^ s;
        x = e ^ {8'h00, m};
        if (k[6]) x = x ^ {m, 8'h00};
        if (!k[7]) return x;
        y = '0;
        for (int i = 0; i < 16; i++) begin
            src  = (opn || !v) ? (3*i + 7) % 16 : (5*i + 3) % 16;
            y[i] = x[src];
        end
        return y;
    endfunction

    function automatic bit model_hit(input int c);
`ifdef JTS16_FD1094_CACHE_EN
        return m_valid[c] && m_addr[c] == c_addr[c] && m_st[c] == c_st[c] &&
               m_op[c] == c_op[c] && m_vrq[c] == c_vrq[c];
`else
        return (c < 0);
`endif
    endfunction

    task automatic model_clear();
        ptr_m = 0;
        for (int c = 0; c < NCH; c++) begin
            last_dec[c] = '0;
            m_valid[c]  = 1'b0;
        end
    endtask

    task automatic apply_ch();
        for (int c = 0; c < NCH; c++) begin
            bus.dec_en[c]          = c_en[c];
            bus.op_n[c]            = c_op[c];
            bus.vrq[c]             = c_vrq[c];
            bus.st[c*8 +: 8]       = c_st[c];
            bus.gkey0[c*8 +: 8]    = c_gk[c];
            bus.addr[c*AW +: AW]   = c_addr[c];
            bus.enc[c*16 +: 16]    = c_enc[c];
        end
    endtask

    task automatic rand_ch(input int c, input logic en);
        c_en[c]   = en;
        c_op[c]   = 1'($urandom);
        c_vrq[c]  = 1'($urandom);
        c_st[c]   = 8'($urandom);
        c_gk[c]   = 8'($urandom);
        c_addr[c] = AW'($urandom);
        c_enc[c]  = 16'($urandom);
    endtask

    task automatic run_txn(input logic [NCH-1:0] mask, input string tag);
        int             exp_edge [NCH];
        int             got_edge [NCH];
        logic [15:0]    exp_dec  [NCH];
        logic [15:0]    got_dec  [NCH];
        logic [KAW-1:0] exp_q [$];
        logic [KAW-1:0] got_q [$];
        int rank, c, last;
        rank = 0;
        last = -1;
        apply_ch();
        for (int k = 0; k < NCH; k++) begin
            c = (ptr_m + k) % NCH;
            exp_edge[c] = -1;
            got_edge[c] = -1;
            got_dec[c]  = '0;
            exp_dec[c]  = last_dec[c];
            if (mask[c]) begin
                if (!c_en[c]) begin
                    exp_edge[c] = 0;
                    exp_dec[c]  = c_enc[c];
                    m_valid[c]  = 1'b0;
                end else if (model_hit(c)) begin
                    exp_edge[c] = 0;
                end else begin
                    exp_edge[c] = 3 + rank;
                    rank++;
                    last = c;
                    exp_q.push_back(c_addr[c][KAW-1:0]);
                    exp_dec[c] = ref_dec(c_enc[c], kram[c_addr[c][KAW-1:0]], c_st[c], c_gk[c],
                                         c_op[c], c_vrq[c]);
                    m_valid[c] = 1'b1;
                    m_addr[c]  = c_addr[c];
                    m_st[c]    = c_st[c];
                    m_op[c]    = c_op[c];
                    m_vrq[c]   = c_vrq[c];
                end
            end
        end
        if (last >= 0) ptr_m = (last + 1) % NCH;
        bus.req = mask;
        for (int e = 0; e < 12; e++) begin
            tick();
            if (bus.key_cs) got_q.push_back(bus.key_addr);
            for (int j = 0; j < NCH; j++)
                if (bus.ok[j] && got_edge[j] < 0) begin
                    got_edge[j] = e;
                    got_dec[j]  = bus.dec[j*16 +: 16];
                end
        end
        for (int j = 0; j < NCH; j++) begin
            chk($sformatf("%s ok%0d edge", tag, j), got_edge[j], exp_edge[j]);
            if (mask[j]) chk($sformatf("%s dec%0d", tag, j), {16'h0, got_dec[j]}, {16'h0, exp_dec[j]});
            last_dec[j] = exp_dec[j];
        end
        chk($sformatf("%s key reads", tag), got_q.size(), exp_q.size());
        for (int j = 0; j < exp_q.size() && j < got_q.size(); j++)
            chk($sformatf("%s key_addr #%0d", tag, j), 32'(got_q[j]), 32'(exp_q[j]));
        bus.req = '0;
        tick();
        chk($sformatf("%s ok fall", tag), 32'(bus.ok), 32'h0);
        for (int j = 0; j < NCH; j++)
            chk($sformatf("%s dec%0d hold", tag, j), {16'h0, bus.dec[j*16 +: 16]}, {16'h0, last_dec[j]});
        tick();
    endtask

    task automatic do_reset(input string tag);
        bus.req = '0;
        rst_n   = 1'b0;
        tick();
        chk({tag, " ok"}, 32'(bus.ok), 32'h0);
        chk({tag, " dec"}, 32'(bus.dec), 32'h0);
        chk({tag, " key_cs"}, 32'(bus.key_cs), 32'h0);
        chk({tag, " key_addr"}, 32'(bus.key_addr), 32'h0);
        tick();
        rst_n = 1'b1;
        model_clear();
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first, other, ge_first, ge_other;
        logic [15:0] gd_other, exp_other;
        logic [NCH-1:0] m;

        for (int i = 0; i < (1 << KAW); i++) kram[i] = 8'($urandom);
        for (int c = 0; c < NCH; c++) rand_ch(c, 1'b1);
        apply_ch();
        bus.req = '0;
        model_clear();

        do_reset("reset");

        // simultaneous requests at reset exit: ch0 first
        rand_ch(0, 1'b1);
        rand_ch(1, 1'b1);
        run_txn(2'b11, "pair0");

        // directed single-channel decrypt
        kram[13'h123] = 8'h5A;
        rand_ch(0, 1'b1);
        c_addr[0] = 23'h000123;
        c_op[0]   = 1'b0;
        c_vrq[0]  = 1'b1;
        run_txn(2'b01, "single");

        // last grant was ch0, so this pair starts at ch1
        rand_ch(0, 1'b1);
        rand_ch(1, 1'b1);
        kram[c_addr[0][KAW-1:0]] = kram[c_addr[0][KAW-1:0]] | 8'h80;
        run_txn(2'b11, "pair1");

        // pass-through channels
        rand_ch(0, 1'b0);
        run_txn(2'b01, "bypass0");
        rand_ch(1, 1'b0);
        c_enc[1] = 16'hBEEF;
        run_txn(2'b10, "bypass1");

        // abort in FETCH for the first-granted channel
        first = ptr_m;
        other = (first + 1) % NCH;
        rand_ch(first, 1'b1);
        rand_ch(other, 1'b1);
        apply_ch();
        exp_other = ref_dec(c_enc[other], kram[c_addr[other][KAW-1:0]], c_st[other], c_gk[other],
                            c_op[other], c_vrq[other]);
        ge_first = -1;
        ge_other = -1;
        gd_other = '0;
        bus.req  = '1;
        for (int e = 0; e < 12; e++) begin
            tick();
            if (e == 1) bus.req[first] = 1'b0;
            if (bus.ok[first] && ge_first < 0) ge_first = e;
            if (bus.ok[other] && ge_other < 0) begin
                ge_other = e;
                gd_other = bus.dec[other*16 +: 16];
            end
        end
        chk("abort ok first", ge_first, -1);
        chk("abort ok other edge", ge_other, 4);
        chk("abort dec other", {16'h0, gd_other}, {16'h0, exp_other});
        chk("abort dec first hold", {16'h0, bus.dec[first*16 +: 16]}, {16'h0, last_dec[first]});
        last_dec[other] = exp_other;
        m_valid[other]  = 1'b1;
        m_addr[other]   = c_addr[other];
        m_st[other]     = c_st[other];
        m_op[other]     = c_op[other];
        m_vrq[other]    = c_vrq[other];
        ptr_m = (other + 1) % NCH;
        bus.req = '0;
        tick();
        tick();

        // randomized traffic
        for (int it = 0; it < 30; it++) begin
            for (int c = 0; c < NCH; c++) rand_ch(c, $urandom_range(0, 3) != 0);
            m = NCH'($urandom_range(1, (1 << NCH) - 1));
            run_txn(m, $sformatf("rand%0d", it));
        end

        // async reset while a channel sits in LATCH
        first = ptr_m;
        rand_ch(first, 1'b1);
        apply_ch();
        bus.req = '0;
        bus.req[first] = 1'b1;
        tick();
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("rst mid ok", 32'(bus.ok), 32'h0);
        chk("rst mid dec", 32'(bus.dec), 32'h0);
        chk("rst mid key_cs", 32'(bus.key_cs), 32'h0);
        bus.req = '0;
        tick();
        #2;
        rst_n = 1'b1;
        model_clear();
        tick();
        rand_ch(0, 1'b1);
        run_txn(2'b01, "post-reset");

`ifdef JTS16_FD1094_CACHE_EN
        rand_ch(0, 1'b1);
        run_txn(2'b01, "cache fill");
        run_txn(2'b01, "cache hit");
        c_st[0] = c_st[0] + 8'd1;
        run_txn(2'b01, "cache st change");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
